// File: rtl/uart_pkt_decoder.sv
// uart_pkt_decoder: decodes 16-bit {type,payload} UART words into remote
// position pairs, button/game state, link liveness and a protocol error count.
// Ports: clk, rst (sync, active-high), uart_en/uart_data (word strobe/data),
//   remote_xpos/remote_ypos/pos_valid, remote_keys/game_state/state_valid,
//   link_up, err_cnt.
// Config: define UART_PKT_DECODER_ERR_CNT_EN to build the error counter;
//   otherwise err_cnt is tied to 0.
module uart_pkt_decoder #(
    parameter int PAIR_TIMEOUT = 65000,
    parameter int LINK_TIMEOUT = 6500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_en,
    input  logic [15:0] uart_data,
    output logic [11:0] remote_xpos,
    output logic [11:0] remote_ypos,
    output logic        pos_valid,
    output logic [3:0]  remote_keys,
    output logic [2:0]  game_state,
    output logic        state_valid,
    output logic        link_up,
    output logic [7:0]  err_cnt
);

    localparam int PW = (PAIR_TIMEOUT > 1) ? $clog2(PAIR_TIMEOUT) : 1;
    localparam int LW = (LINK_TIMEOUT > 1) ? $clog2(LINK_TIMEOUT) : 1;

    localparam logic [PW-1:0] PAIR_LAST = PW'(PAIR_TIMEOUT - 1);
    localparam logic [LW-1:0] LINK_LAST = LW'(LINK_TIMEOUT - 1);

    localparam logic [3:0] T_POS_X = 4'h1;
    localparam logic [3:0] T_POS_Y = 4'h2;
    localparam logic [3:0] T_KEYS  = 4'h3;
    localparam logic [3:0] T_GAME  = 4'h4;
    localparam logic [3:0] T_HBEAT = 4'hF;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT_Y
    } state_t;

    state_t        state, state_nxt;
    logic [11:0]   pend_x, pend_nxt;
    logic [PW-1:0] pair_cnt, pair_nxt;
    logic [LW-1:0] link_cnt, link_cnt_nxt;
    logic          link_up_nxt;
    logic          upd_pos;

    logic [3:0]  typ;
    logic [11:0] payload;
    logic        is_x, is_y, is_keys, is_game, is_hb, is_known;

    assign typ     = uart_data[15:12];
    assign payload = uart_data[11:0];

    assign is_x     = uart_en && (typ == T_POS_X);
    assign is_y     = uart_en && (typ == T_POS_Y);
    assign is_keys  = uart_en && (typ == T_KEYS);
    assign is_game  = uart_en && (typ == T_GAME);
    assign is_hb    = uart_en && (typ == T_HBEAT);
    assign is_known = is_x | is_y | is_keys | is_game | is_hb;

    // Pairing FSM. In ST_WAIT_Y an accepted POS_Y wins over the timeout,
    // and a fresh POS_X restarts the wait rather than timing out.
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend_x;
        pair_nxt  = pair_cnt;
        upd_pos   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (is_x) begin
                    pend_nxt  = payload;
                    pair_nxt  = '0;
                    state_nxt = ST_WAIT_Y;
                end
            end
            ST_WAIT_Y: begin
                if (is_y) begin
                    upd_pos   = 1'b1;
                    pair_nxt  = '0;
                    state_nxt = ST_IDLE;
                end else if (is_x) begin
                    pend_nxt = payload;
                    pair_nxt = '0;
                end else if (pair_cnt == PAIR_LAST) begin
                    pend_nxt  = '0;
                    pair_nxt  = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    pair_nxt = pair_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Link watchdog: only recognised word types refresh it; the counter
    // parks at its last value so link_up stays low until the next word.
    always_comb begin
        link_cnt_nxt = link_cnt;
        link_up_nxt  = link_up;
        if (is_known) begin
            link_cnt_nxt = '0;
            link_up_nxt  = 1'b1;
        end else begin
            if (link_cnt != LINK_LAST) begin
                link_cnt_nxt = link_cnt + 1'b1;
            end
            if (link_cnt_nxt == LINK_LAST) begin
                link_up_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pend_x      <= '0;
            pair_cnt    <= '0;
            link_cnt    <= '0;
            link_up     <= 1'b0;
            remote_xpos <= '0;
            remote_ypos <= '0;
            pos_valid   <= 1'b0;
            remote_keys <= '0;
            game_state  <= '0;
            state_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            pend_x    <= pend_nxt;
            pair_cnt  <= pair_nxt;
            link_cnt  <= link_cnt_nxt;
            link_up   <= link_up_nxt;
            pos_valid <= upd_pos;
            if (upd_pos) begin
                remote_xpos <= pend_x;
                remote_ypos <= payload;
            end
            if (is_keys) begin
                remote_keys <= payload[3:0];
            end
            if (is_game) begin
                game_state <= payload[2:0];
            end
            state_valid <= is_keys | is_game;
        end
    end

`ifdef UART_PKT_DECODER_ERR_CNT_EN
    logic       err_pair;
    logic       err_any;
    logic [7:0] err_q;

    // Pairing errors: stray POS_Y, a repeated POS_X, or the pair timeout.
    always_comb begin
        err_pair = 1'b0;
        if (state == ST_IDLE) begin
            err_pair = is_y;
        end else if (!is_y) begin
            err_pair = is_x || (pair_cnt == PAIR_LAST);
        end
    end

    // Coincident sources collapse into a single increment.
    assign err_any = err_pair | (uart_en & ~is_known);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else if (err_any && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_uart_pkt_decoder.sv
// tb_uart_pkt_decoder: directed self-checking bench for uart_pkt_decoder
// with PAIR_TIMEOUT=20 and LINK_TIMEOUT=100.
module tb_uart_pkt_decoder;

    localparam int PT = 20;
    localparam int LT = 100;

`ifdef UART_PKT_DECODER_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_en = 1'b0;
    logic [15:0] uart_data = '0;
    logic [11:0] remote_xpos;
    logic [11:0] remote_ypos;
    logic        pos_valid;
    logic [3:0]  remote_keys;
    logic [2:0]  game_state;
    logic        state_valid;
    logic        link_up;
    logic [7:0]  err_cnt;

    int n_chk = 0;
    int n_pass = 0;

    uart_pkt_decoder #(
        .PAIR_TIMEOUT(PT),
        .LINK_TIMEOUT(LT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .uart_en(uart_en),
        .uart_data(uart_data),
        .remote_xpos(remote_xpos),
        .remote_ypos(remote_ypos),
        .pos_valid(pos_valid),
        .remote_keys(remote_keys),
        .game_state(game_state),
        .state_valid(state_valid),
        .link_up(link_up),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] e_err(input int n);
        return ERR_EN ? 32'(n) : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [15:0] w);
        uart_en   = 1'b1;
        uart_data = w;
        tick();
        uart_en   = 1'b0;
        uart_data = '0;
    endtask

    task automatic do_reset();
        uart_en = 1'b0;
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_xpos", 32'(remote_xpos), 0);
        chk("rst_ypos", 32'(remote_ypos), 0);
        chk("rst_pv", 32'(pos_valid), 0);
        chk("rst_keys", 32'(remote_keys), 0);
        chk("rst_gs", 32'(game_state), 0);
        chk("rst_sv", 32'(state_valid), 0);
        chk("rst_link", 32'(link_up), 0);
        chk("rst_err", 32'(err_cnt), 0);

        // basic pair
        send(16'h1123);
        chk("pair_x_only_pv", 32'(pos_valid), 0);
        send(16'h2045);
        chk("pair_xpos", 32'(remote_xpos), 32'h123);
        chk("pair_ypos", 32'(remote_ypos), 32'h045);
        chk("pair_pv", 32'(pos_valid), 1);
        chk("pair_link", 32'(link_up), 1);
        tick();
        chk("pair_pv_drop", 32'(pos_valid), 0);

        // pair timeout then stray POS_Y
        do_reset();
        send(16'h1010);
        ticks(PT);
        send(16'h2020);
        chk("tmo_pv", 32'(pos_valid), 0);
        chk("tmo_xpos", 32'(remote_xpos), 0);
        chk("tmo_err", 32'(err_cnt), e_err(2));

        // POS_Y on the last wait cycle still completes the pair
        do_reset();
        send(16'h1ABC);
        ticks(PT - 1);
        send(16'h2DEF);
        chk("edge_pv", 32'(pos_valid), 1);
        chk("edge_xpos", 32'(remote_xpos), 32'hABC);
        chk("edge_ypos", 32'(remote_ypos), 32'hDEF);
        chk("edge_err", 32'(err_cnt), 0);

        // timeout and unknown type together count once
        do_reset();
        send(16'h1055);
        ticks(PT - 1);
        send(16'h9000);
        chk("coin_err", 32'(err_cnt), e_err(1));
        send(16'h2066);
        chk("coin_pv", 32'(pos_valid), 0);
        chk("coin_err2", 32'(err_cnt), e_err(2));

        // interleaved KEYS / GAME_STATE during wait
        do_reset();
        send(16'h1100);
        send(16'h300A);
        chk("il_keys", 32'(remote_keys), 32'hA);
        chk("il_sv", 32'(state_valid), 1);
        chk("il_pv0", 32'(pos_valid), 0);
        send(16'h4005);
        chk("il_gs", 32'(game_state), 5);
        chk("il_keys_hold", 32'(remote_keys), 32'hA);
        chk("il_sv2", 32'(state_valid), 1);
        send(16'h2200);
        chk("il_xpos", 32'(remote_xpos), 32'h100);
        chk("il_ypos", 32'(remote_ypos), 32'h200);
        chk("il_pv", 32'(pos_valid), 1);
        chk("il_sv_drop", 32'(state_valid), 0);
        chk("il_err", 32'(err_cnt), 0);

        // repeated POS_X replaces pending X
        do_reset();
        send(16'h1111);
        send(16'h1222);
        chk("rx_err", 32'(err_cnt), e_err(1));
        send(16'h2333);
        chk("rx_xpos", 32'(remote_xpos), 32'h222);
        chk("rx_ypos", 32'(remote_ypos), 32'h333);
        chk("rx_pv", 32'(pos_valid), 1);

        // link watchdog
        do_reset();
        send(16'hF000);
        chk("lk_up", 32'(link_up), 1);
        ticks(LT - 2);
        chk("lk_up_last", 32'(link_up), 1);
        tick();
        chk("lk_down", 32'(link_up), 0);
        send(16'h7000);
        send(16'h7000);
        send(16'h7000);
        chk("lk_unknown", 32'(link_up), 0);
        chk("lk_err", 32'(err_cnt), e_err(3));
        send(16'hF000);
        chk("lk_restore", 32'(link_up), 1);

        // error saturation
        do_reset();
        for (int i = 0; i < 300; i++) send(16'h9000);
        chk("sat_err", 32'(err_cnt), e_err(255));
        chk("sat_link", 32'(link_up), 0);

        // reset mid-pair, with a word presented during reset
        do_reset();
        send(16'h1777);
        rst       = 1'b1;
        uart_en   = 1'b1;
        uart_data = 16'h300F;
        tick();
        rst       = 1'b0;
        uart_en   = 1'b0;
        uart_data = '0;
        chk("mr_keys", 32'(remote_keys), 0);
        chk("mr_sv", 32'(state_valid), 0);
        chk("mr_link", 32'(link_up), 0);
        send(16'h2001);
        chk("mr_pv", 32'(pos_valid), 0);
        chk("mr_xpos", 32'(remote_xpos), 0);
        chk("mr_ypos", 32'(remote_ypos), 0);
        chk("mr_gs", 32'(game_state), 0);
        chk("mr_err", 32'(err_cnt), e_err(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_pkt_decoder.md
UART_PKT_DECODER -- requirements
Module: uart_pkt_decoder

Interface
REQ-001 SHALL have parameter PAIR_TIMEOUT, 65000, maximum cycles to wait for POS_Y after POS_X.
REQ-002 SHALL have parameter LINK_TIMEOUT, 6500000, cycles without a valid word before link_up deasserts.
REQ-003 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port uart_en  in  1  one-cycle strobe marking uart_data valid.
REQ-006 SHALL have port uart_data  in  16  received word {type[15:12], payload[11:0]}.
REQ-007 SHALL have port remote_xpos  out  12  last complete remote X position.
REQ-008 SHALL have port remote_ypos  out  12  last complete remote Y position.
REQ-009 SHALL have port pos_valid  out  1  one-cycle pulse on position pair update.
REQ-010 SHALL have port remote_keys  out  4  last received button state.
REQ-011 SHALL have port game_state  out  3  last received game state code.
REQ-012 SHALL have port state_valid  out  1  one-cycle pulse on KEYS or GAME_STATE update.
REQ-013 SHALL have port link_up  out  1  level, remote board alive.
REQ-014 SHALL have port err_cnt  out  8  saturating protocol error count.

Function
REQ-015 SHALL decode types: 0x1 POS_X, 0x2 POS_Y, 0x3 KEYS (payload[3:0]), 0x4 GAME_STATE (payload[2:0]), 0xF HEARTBEAT; every other type is an error.
REQ-016 SHALL sample uart_data only in cycles where uart_en=1; all outputs are registered, so a word accepted in cycle N is visible on outputs in cycle N+1.
REQ-017 SHALL implement FSM states ST_IDLE and ST_WAIT_Y.
REQ-018 SHALL, in ST_IDLE on POS_X, latch payload into a pending-X register, clear the pair counter, and go to ST_WAIT_Y.
REQ-019 SHALL, in ST_WAIT_Y on POS_Y, update remote_xpos=pending X and remote_ypos=payload in the same cycle, pulse pos_valid, and return to ST_IDLE.
REQ-020 SHALL treat POS_Y in ST_IDLE as an error; outputs unchanged.
REQ-021 SHALL, in ST_WAIT_Y on a second POS_X, count one error, replace pending X with the new payload, and stay in ST_WAIT_Y with the pair counter cleared.
REQ-022 SHALL, in ST_WAIT_Y on KEYS, GAME_STATE or HEARTBEAT, process that word normally and stay in ST_WAIT_Y.
REQ-023 SHALL, in ST_WAIT_Y when the pair counter reaches PAIR_TIMEOUT-1 with no POS_Y, discard pending X, count one error, and return to ST_IDLE.
REQ-024 SHALL give an accepted POS_Y priority over pair timeout expiry in the same cycle.
REQ-025 SHALL, on KEYS or GAME_STATE, update only the addressed output and pulse state_valid for one cycle.
REQ-026 SHALL clear the link counter on every word with a valid type and assert link_up in the next cycle.
REQ-027 SHALL deassert link_up when the link counter reaches LINK_TIMEOUT-1; the counter holds there until the next valid word.
REQ-028 SHALL not let unknown-type words refresh the link counter.
REQ-029 SHALL saturate err_cnt at 255 and never wrap.
REQ-030 SHALL increment err_cnt by exactly 1 when two error sources coincide in one cycle.

Reset
REQ-031 SHALL, on rst, force ST_IDLE, clear all counters and pending X, and drive every output to 0 (link_up=0) from the next edge.
REQ-032 SHALL discard a half-received pair and ignore uart_en in any cycle where rst is asserted.

Configuration
REQ-033 SHALL compile the error counter only when macro UART_PKT_DECODER_ERR_CNT_EN is defined; otherwise err_cnt is constant 0, no counter is built, and all other behaviour is identical.

Verification
REQ-034 SHALL check: POS_X 0x1123 then POS_Y 0x2045 -> next cycle xpos=0x123, ypos=0x045, pos_valid high exactly 1 cycle.
REQ-035 SHALL check: POS_X 0x1010, then no word for PAIR_TIMEOUT cycles, then POS_Y 0x2020 -> no pos_valid, err_cnt=2.
REQ-036 SHALL check: POS_X 0x1100, KEYS 0x300A, POS_Y 0x2200 -> keys=0xA with state_valid, then xpos=0x100, ypos=0x200.
REQ-037 SHALL check: HEARTBEAT 0xF000, then idle LINK_TIMEOUT cycles (bench overrides parameter to 100) -> link_up 1 then 0 at cycle 100; 0x7000 words do not restore it.
REQ-038 SHALL check: 300 words of type 0x9 with macro defined -> err_cnt=255; with macro undefined -> err_cnt=0.
REQ-039 SHALL check: rst asserted in ST_WAIT_Y after POS_X 0x1777, then POS_Y 0x2001 -> all outputs 0, no pos_valid, err_cnt=1.
